// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC processor control path.
// Provides the sequencer state enum, PC/index widths and typedefs, and a
// modulo PC increment helper used by the next-PC logic.
package cordic_pkg;

   localparam int unsigned PC_W  = 9;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 16;

   typedef logic [PC_W-1:0]  pc_t;
   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   // PC + 1, wrapping modulo 2^PC_W without a carry out
   function automatic pc_t pc_inc(input pc_t pc);
      return pc + pc_t'(1);
   endfunction

   // Saturating run-cycle counter increment
   function automatic cnt_t cnt_sat_inc(input cnt_t cnt);
      return (cnt == '1) ? cnt : cnt + cnt_t'(1);
   endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select and jump-index range check.
// Optional feature macro: PC_SEQ_LINK_REG_EN (adds call/return selection).
// Ports:
//   i_pc        current PC
//   i_halt      hold the PC
//   i_jump_en   unconditional jump
//   i_branch_en taken conditional branch
//   i_index     jump-index field
//   i_target    LUT target for i_index
//   i_call/i_ret/i_link (macro only) call, return, current link value
//   o_link_we   (macro only) load link with PC+1
//   o_next_pc   selected next PC
//   o_bad_index taken jump/call with an out-of-range index
module pc_next
   import cordic_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 13
) (
   input  pc_t  i_pc,
   input  logic i_halt,
   input  logic i_jump_en,
   input  logic i_branch_en,
   input  idx_t i_index,
   input  pc_t  i_target,
`ifdef PC_SEQ_LINK_REG_EN
   input  logic i_call,
   input  logic i_ret,
   input  pc_t  i_link,
   output logic o_link_we,
`endif
   output pc_t  o_next_pc,
   output logic o_bad_index
);

   logic w_idx_ok;
   pc_t  w_pc_inc;

   assign w_idx_ok = (32'(i_index) < NUM_ENTRIES);
   assign w_pc_inc = pc_inc(i_pc);

   // Priority: halt > ret > call > jump/branch > increment
   always_comb begin
      o_next_pc   = w_pc_inc;
      o_bad_index = 1'b0;
`ifdef PC_SEQ_LINK_REG_EN
      o_link_we   = 1'b0;
`endif
      if (i_halt) begin
         o_next_pc = i_pc;
`ifdef PC_SEQ_LINK_REG_EN
      end else if (i_ret) begin
         o_next_pc = i_link;
      end else if (i_call) begin
         o_link_we = 1'b1;
         if (w_idx_ok) begin
            o_next_pc = i_target;
         end else begin
            o_bad_index = 1'b1;
         end
`endif
      end else if (i_jump_en || i_branch_en) begin
         if (w_idx_ok) begin
            o_next_pc = i_target;
         end else begin
            o_bad_index = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: requesting side of the jump-target LUT.
// Holds the PC, passes the jump index to the LUT, selects the next PC,
// and counts RUN cycles. The LUT itself lives beside this block.
// Optional feature macro: PC_SEQ_LINK_REG_EN (one-deep call/return link).
// Ports:
//   Clk, Reset_n        clock, async active-low reset
//   Start               begin a run (ignored while running)
//   Halt/JumpEn/BranchEn/Index  decoded control for the current PC
//   Target              LUT result for LutIndex
//   Call/Ret            (macro only) call and return
//   LutIndex            combinational copy of Index
//   PC                  current program counter
//   Busy/Done           registered RUN / DONE state flags
//   BadIndex            one-cycle pulse after a taken jump with bad index
//   CycleCount          saturating RUN-cycle count
module pc_sequencer
   import cordic_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 13,
   parameter pc_t         START_PC    = '0
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Start,
   input  logic Halt,
   input  logic JumpEn,
   input  logic BranchEn,
   input  idx_t Index,
   input  pc_t  Target,
`ifdef PC_SEQ_LINK_REG_EN
   input  logic Call,
   input  logic Ret,
`endif
   output idx_t LutIndex,
   output pc_t  PC,
   output logic Busy,
   output logic Done,
   output logic BadIndex,
   output cnt_t CycleCount
);

   seq_state_t r_state;
   seq_state_t w_state_nxt;

   pc_t  r_pc;
   cnt_t r_cnt;
   logic r_busy;
   logic r_done;
   logic r_bad;

   pc_t  w_pc_nxt;
   cnt_t w_cnt_nxt;
   logic w_busy_nxt;
   logic w_done_nxt;
   logic w_bad_nxt;

   pc_t  w_sel_pc;
   logic w_sel_bad;

`ifdef PC_SEQ_LINK_REG_EN
   pc_t  r_link;
   pc_t  w_link_nxt;
   logic w_link_we;
`endif

   assign LutIndex = Index;

   pc_next #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_pc_next (
      .i_pc        (r_pc),
      .i_halt      (Halt),
      .i_jump_en   (JumpEn),
      .i_branch_en (BranchEn),
      .i_index     (Index),
      .i_target    (Target),
`ifdef PC_SEQ_LINK_REG_EN
      .i_call      (Call),
      .i_ret       (Ret),
      .i_link      (r_link),
      .o_link_we   (w_link_we),
`endif
      .o_next_pc   (w_sel_pc),
      .o_bad_index (w_sel_bad)
   );

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (Start) w_state_nxt = ST_RUN;
         ST_RUN:  if (Halt)  w_state_nxt = ST_DONE;
         ST_DONE: if (Start) w_state_nxt = ST_RUN;
         default:            w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and flag next values
   always_comb begin
      w_pc_nxt   = r_pc;
      w_cnt_nxt  = r_cnt;
      w_bad_nxt  = 1'b0;
      w_busy_nxt = (w_state_nxt == ST_RUN);
      w_done_nxt = (w_state_nxt == ST_DONE);
`ifdef PC_SEQ_LINK_REG_EN
      w_link_nxt = r_link;
`endif
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               w_pc_nxt  = START_PC;
               w_cnt_nxt = '0;
            end
         end
         ST_RUN: begin
            w_pc_nxt  = w_sel_pc;
            w_bad_nxt = w_sel_bad;
            w_cnt_nxt = cnt_sat_inc(r_cnt);
`ifdef PC_SEQ_LINK_REG_EN
            if (w_link_we) w_link_nxt = pc_inc(r_pc);
`endif
         end
         default: begin
            w_pc_nxt = r_pc;
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_pc   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_bad  <= 1'b0;
      end else begin
         r_pc   <= w_pc_nxt;
         r_cnt  <= w_cnt_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_bad  <= w_bad_nxt;
      end
   end

`ifdef PC_SEQ_LINK_REG_EN
   // One-deep return-address register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_link <= '0;
      end else begin
         r_link <= w_link_nxt;
      end
   end
`endif

   assign PC         = r_pc;
   assign CycleCount = r_cnt;
   assign Busy       = r_busy;
   assign Done       = r_done;
   assign BadIndex   = r_bad;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a bench-side reference model and
// an expected-result queue; the jump LUT is modelled here.
module tb_pc_sequencer;
   import cordic_pkg::*;

   typedef struct {
      pc_t  pc;
      logic busy;
      logic done;
      logic bad;
      cnt_t cnt;
   } exp_t;

   logic Clk, Reset_n, Start, Halt, JumpEn, BranchEn, Call, Ret;
   idx_t Index, LutIndex;
   pc_t  Target, PC;
   logic Busy, Done, BadIndex;
   cnt_t CycleCount;

   int n_checks = 0;
   int n_errors = 0;

   pc_t  lut [16];
   exp_t sb_q [$];

   // model state: 0 idle, 1 run, 2 done
   int   m_state;
   pc_t  m_pc;
   pc_t  m_link;
   cnt_t m_cnt;
   logic m_bad;

   pc_sequencer #(.NUM_ENTRIES(13), .START_PC(9'd0)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .Start      (Start),
      .Halt       (Halt),
      .JumpEn     (JumpEn),
      .BranchEn   (BranchEn),
      .Index      (Index),
      .Target     (Target),
`ifdef PC_SEQ_LINK_REG_EN
      .Call       (Call),
      .Ret        (Ret),
`endif
      .LutIndex   (LutIndex),
      .PC         (PC),
      .Busy       (Busy),
      .Done       (Done),
      .BadIndex   (BadIndex),
      .CycleCount (CycleCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Combinational jump LUT
   always_comb Target = lut[LutIndex];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_pc    = '0;
      m_link  = '0;
      m_cnt   = '0;
      m_bad   = 1'b0;
   endtask

   // Drive one cycle of inputs, predict, clock, then compare against the queue
   task automatic cyc(input logic st, input logic hl, input logic jp, input logic br,
                      input logic cl, input logic rt, input idx_t ix);
      exp_t e;
      exp_t g;
      Start = st; Halt = hl; JumpEn = jp; BranchEn = br; Call = cl; Ret = rt; Index = ix;
      m_bad = 1'b0;
      if (m_state != 1) begin
         if (st) begin
            m_state = 1;
            m_pc    = 9'd0;
            m_cnt   = 16'd0;
         end
      end else begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`ifndef PC_SEQ_LINK_REG_EN
         cl = 1'b0;
         rt = 1'b0;
`endif
         if (hl) begin
            m_state = 2;
         end else if (rt) begin
            m_pc = m_link;
         end else if (cl || jp || br) begin
            if (cl) m_link = m_pc + 9'd1;
            if (int'(ix) < 13) m_pc = lut[ix];
            else begin
               m_pc  = m_pc + 9'd1;
               m_bad = 1'b1;
            end
         end else begin
            m_pc = m_pc + 9'd1;
         end
      end
      e.pc = m_pc; e.busy = (m_state == 1); e.done = (m_state == 2);
      e.bad = m_bad; e.cnt = m_cnt;
      sb_q.push_back(e);
      @(posedge Clk);
      #1;
      g = sb_q.pop_front();
      chk("pc",    32'(PC),         32'(g.pc));
      chk("busy",  32'(Busy),       32'(g.busy));
      chk("done",  32'(Done),       32'(g.done));
      chk("bad",   32'(BadIndex),   32'(g.bad));
      chk("count", 32'(CycleCount), 32'(g.cnt));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) lut[i] = pc_t'(9'd200 + 9'(i));
      lut[1] = 9'd20;  lut[2] = 9'd128; lut[3] = 9'd53;
      lut[4] = 9'd508; lut[5] = 9'd40;  lut[7] = 9'd112;
      lut[13] = 9'd77; lut[15] = 9'd99;

      Reset_n = 1'b0; Start = 0; Halt = 0; JumpEn = 0; BranchEn = 0;
      Call = 0; Ret = 0; Index = '0;
      model_reset();
      #12;
      chk("rst_pc",    32'(PC), 32'd0);
      chk("rst_busy",  32'(Busy), 32'd0);
      chk("rst_done",  32'(Done), 32'd0);
      chk("rst_bad",   32'(BadIndex), 32'd0);
      chk("rst_count", 32'(CycleCount), 32'd0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;

      // Control inputs ignored in IDLE
      cyc(0, 1, 1, 0, 0, 0, 4'd3);
      cyc(1, 0, 0, 0, 0, 0, 4'd0);
      chk("start_busy", 32'(Busy), 32'd1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 4'd0);
      chk("pc_after5",  32'(PC), 32'd5);
      chk("cnt_after5", 32'(CycleCount), 32'd5);

      cyc(0, 0, 1, 0, 0, 0, 4'd3);
      chk("jump53", 32'(PC), 32'd53);
      cyc(0, 0, 1, 0, 0, 0, 4'd1);
      cyc(0, 0, 0, 1, 0, 0, 4'd13);
      chk("badidx_pc",  32'(PC), 32'd21);
      chk("badidx_hi",  32'(BadIndex), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 4'd0);
      chk("badidx_lo",  32'(BadIndex), 32'd0);

      // Halt at 128, DONE ignores controls, restart reloads
      cyc(0, 0, 1, 0, 0, 0, 4'd2);
      cyc(0, 1, 0, 0, 0, 0, 4'd0);
      chk("halt_pc",   32'(PC), 32'd128);
      chk("halt_done", 32'(Done), 32'd1);
      cyc(0, 0, 1, 0, 0, 0, 4'd3);
      cyc(0, 1, 0, 1, 0, 0, 4'd5);
      cyc(1, 0, 0, 0, 0, 0, 4'd0);
      chk("restart_pc",  32'(PC), 32'd0);
      chk("restart_cnt", 32'(CycleCount), 32'd0);

      // Start in RUN ignored; invalid index 15; wrap 511 -> 0
      cyc(1, 0, 0, 0, 0, 0, 4'd0);
      cyc(0, 0, 1, 0, 0, 0, 4'd15);
      cyc(0, 0, 1, 0, 0, 0, 4'd4);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 4'd0);
      chk("pc511", 32'(PC), 32'd511);
      cyc(0, 0, 0, 0, 0, 0, 4'd0);
      chk("wrap0", 32'(PC), 32'd0);
      chk("wrap_nobad", 32'(BadIndex), 32'd0);

`ifdef PC_SEQ_LINK_REG_EN
      cyc(0, 0, 1, 0, 0, 0, 4'd5);
      cyc(0, 0, 0, 0, 1, 0, 4'd7);
      chk("call112", 32'(PC), 32'd112);
      cyc(0, 0, 0, 0, 0, 1, 4'd0);
      chk("ret41", 32'(PC), 32'd41);
      cyc(0, 0, 0, 0, 1, 1, 4'd7);
      chk("ret_wins", 32'(PC), 32'd41);
`endif

      // Asynchronous reset mid-run
      cyc(0, 0, 0, 0, 0, 0, 4'd0);
      #3;
      Reset_n = 1'b0;
      model_reset();
      #1;
      chk("arst_pc",    32'(PC), 32'd0);
      chk("arst_busy",  32'(Busy), 32'd0);
      chk("arst_count", 32'(CycleCount), 32'd0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 4'd0);
      cyc(0, 0, 1, 0, 0, 0, 4'd3);
      chk("idle_after_rst", 32'(PC), 32'd0);

      Start = 0; Halt = 0; JumpEn = 0; BranchEn = 0; Call = 0; Ret = 0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
